// File: rtl/gcd_shared_ctrl.sv
// Two-port round-robin GCD controller driving a shared subtract datapath.
// Define GCD_ITER_CNT_EN to add the per-job iter_cnt subtraction counter output.
module gcd_shared_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result0,
    output logic [WIDTH-1:0] result1,
    output logic             busy,
    output logic [WIDTH-1:0] data_in,
    output logic             ldA,
    output logic             ldB,
    output logic             sel1,
    output logic             sel2,
    output logic             sel_in,
    input  logic             lt,
    input  logic             gt,
    input  logic             eq,
    input  logic [WIDTH-1:0] Aout
`ifdef GCD_ITER_CNT_EN
    ,
    output logic [15:0]      iter_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        LOAD_A,
        LOAD_B,
        ITER,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             cur_q;
    logic             last_q;
    logic             win;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // On a tie the port not served last wins.
    assign win   = (req0 & req1) ? ~last_q : req1;
    assign sel_a = cur_q ? a1 : a0;
    assign sel_b = cur_q ? b1 : b0;
    assign busy  = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        data_in = '0;
        ldA     = 1'b0;
        ldB     = 1'b0;
        sel1    = 1'b0;
        sel2    = 1'b0;
        sel_in  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 | req1) state_d = GRANT;
            end
            GRANT: begin
                if ((sel_a == '0) || (sel_b == '0)) state_d = DONE;
                else                                state_d = LOAD_A;
            end
            LOAD_A: begin
                data_in = a_q;
                sel_in  = 1'b1;
                ldA     = 1'b1;
                state_d = LOAD_B;
            end
            LOAD_B: begin
                data_in = b_q;
                sel_in  = 1'b1;
                ldB     = 1'b1;
                state_d = ITER;
            end
            ITER: begin
                // No compare flag set: hold and load nothing.
                unique case (1'b1)
                    eq: state_d = DONE;
                    gt: begin
                        sel1 = 1'b1;
                        ldA  = 1'b1;
                    end
                    lt: begin
                        sel2 = 1'b1;
                        ldB  = 1'b1;
                    end
                    default: state_d = ITER;
                endcase
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= 1'b0;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            result0 <= '0;
            result1 <= '0;
        end else begin
            state_q <= state_d;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 | req1) cur_q <= win;
                end
                GRANT: begin
                    a_q    <= sel_a;
                    b_q    <= sel_b;
                    res_q  <= sel_a | sel_b;
                    gnt0   <= ~cur_q;
                    gnt1   <= cur_q;
                    last_q <= cur_q;
                end
                ITER: begin
                    if (eq) res_q <= Aout;
                end
                DONE: begin
                    if (cur_q) begin
                        result1 <= res_q;
                        done1   <= 1'b1;
                    end else begin
                        result0 <= res_q;
                        done0   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GCD_ITER_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            iter_cnt <= '0;
        end else begin
            if (state_q == GRANT) begin
                cnt_q <= '0;
            end else if ((state_q == ITER) && (ldA | ldB)
                         && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (state_q == DONE) iter_cnt <= cnt_q;
        end
    end
`endif

endmodule

// File: tb/tb_gcd_shared_ctrl.sv
// Randomized + directed bench for gcd_shared_ctrl with an Euclid-based job model.
// Honours GCD_ITER_CNT_EN to connect and check iter_cnt.
module tb_gcd_shared_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [15:0] a0, b0, a1, b1;
    logic        gnt0, gnt1, done0, done1, busy;
    logic [15:0] result0, result1, data_in;
    logic        ldA, ldB, sel1, sel2, sel_in;
    logic        lt, gt, eq;
    logic [15:0] Aout;
`ifdef GCD_ITER_CNT_EN
    logic [15:0] iter_cnt;
`endif

    always #5 clk = ~clk;

    gcd_shared_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result0(result0), .result1(result1), .busy(busy),
        .data_in(data_in), .ldA(ldA), .ldB(ldB),
        .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
        .lt(lt), .gt(gt), .eq(eq), .Aout(Aout)
`ifdef GCD_ITER_CNT_EN
        , .iter_cnt(iter_cnt)
`endif
    );

    // Shared datapath: two registers, load mux, subtractor, comparator.
    logic [15:0] ra = 16'd0;
    logic [15:0] rb = 16'd0;
    logic [15:0] dp_sub;
    assign dp_sub = (sel1 ? ra : rb) - (sel2 ? ra : rb);
    always @(posedge clk) begin
        if (ldA) ra <= sel_in ? data_in : dp_sub;
        if (ldB) rb <= sel_in ? data_in : dp_sub;
    end
    assign lt   = ra < rb;
    assign gt   = ra > rb;
    assign eq   = ra == rb;
    assign Aout = ra;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Job-level model
    bit          m_act = 0;
    bit          m_port = 0;
    bit          m_last = 1;
    int          m_cnt = 0;
    int          m_dur = 99;
    int          m_n = 0;
    int          m_ld = 0;
    int          ldc = 0;
    logic [15:0] m_res = 0;
    logic        e_gnt0 = 0, e_gnt1 = 0, e_done0 = 0, e_done1 = 0;
    logic [15:0] e_res0 = 0, e_res1 = 0, e_iter = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // gcd via Euclid; subtraction count = sum of quotients - 1
    task automatic gcd_ref(input int x, input int y, output int g,
                           output int n, output bit byp);
        int p, q, t;
        byp = (x == 0) || (y == 0);
        g = x | y;
        n = 0;
        if (!byp) begin
            p = x; q = y; n = -1;
            while (q != 0) begin
                n += p / q;
                t = p % q;
                p = q;
                q = t;
            end
            g = p;
        end
    endtask

    task automatic model_update();
        int g, n;
        bit byp;
        cyc++;
        e_gnt0 = 0; e_gnt1 = 0; e_done0 = 0; e_done1 = 0;
        if (rst) begin
            m_act = 0; m_last = 1; m_dur = 99; ldc = 0;
            e_res0 = 0; e_res1 = 0; e_iter = 0;
            return;
        end
        if (m_act) begin
            m_cnt++;
            if (m_cnt == 1) begin
                gcd_ref(int'(m_port ? a1 : a0), int'(m_port ? b1 : b0), g, n, byp);
                m_res = 16'(g);
                m_n = n;
                m_dur = byp ? 2 : 5 + n;
                m_ld = byp ? 0 : n + 2;
                if (m_port) e_gnt1 = 1; else e_gnt0 = 1;
                m_last = m_port;
            end
            if (m_cnt == m_dur) begin
                if (m_port) begin e_done1 = 1; e_res1 = m_res; end
                else        begin e_done0 = 1; e_res0 = m_res; end
                e_iter = 16'(m_n);
                m_act = 0;
                m_dur = 99;
            end
        end else if (req0 || req1) begin
            m_port = (req0 && req1) ? !m_last : req1;
            m_act = 1;
            m_cnt = 0;
        end
    endtask

    task automatic compare();
        chk("gnt0", gnt0, e_gnt0);
        chk("gnt1", gnt1, e_gnt1);
        chk("done0", done0, e_done0);
        chk("done1", done1, e_done1);
        chk("result0", result0, e_res0);
        chk("result1", result1, e_res1);
        chk("busy", busy, m_act);
`ifdef GCD_ITER_CNT_EN
        chk("iter_cnt", iter_cnt, e_iter);
`endif
        if (!m_act) chk("idle_ld", {ldA, ldB, data_in}, 0);
        if (m_act) ldc += int'(ldA) + int'(ldB);
        if (e_done0 || e_done1) begin
            chk("ld_pulses", ldc, m_ld);
            ldc = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic run_job(input bit p, input logic [15:0] x,
                           input logic [15:0] y, output int lat,
                           output logic [15:0] res);
        int samp;
        bit ok;
        ok = 0; lat = -1; res = 0;
        if (p) begin a1 = x; b1 = y; req1 = 1; end
        else   begin a0 = x; b0 = y; req0 = 1; end
        samp = cyc + 1;
        for (int k = 0; k < 400 && !ok; k++) begin
            step();
            if (gnt0) req0 = 0;
            if (gnt1) req1 = 0;
            if (p ? done1 : done0) begin
                ok = 1;
                lat = cyc - samp;
                res = p ? result1 : result0;
            end
        end
        chk("job_timeout", ok, 1);
    endtask

    task automatic run_pair(input logic [15:0] x0, input logic [15:0] y0,
                            input logic [15:0] x1, input logic [15:0] y1,
                            output int t0, output int t1);
        t0 = -1; t1 = -1;
        a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        req0 = 1; req1 = 1;
        for (int k = 0; k < 400 && (t0 < 0 || t1 < 0); k++) begin
            step();
            if (gnt0) req0 = 0;
            if (gnt1) req1 = 0;
            if (done0) t0 = cyc;
            if (done1) t1 = cyc;
        end
        chk("pair_timeout", (t0 >= 0) && (t1 >= 0), 1);
    endtask

    function automatic logic [15:0] rnd_op();
        if ($urandom_range(7) == 0) return 16'd0;
        return 16'($urandom_range(255, 1));
    endfunction

    initial begin
        int lat, t0, t1, wt0, wt1;
        logic [15:0] r;
        rst = 1; req0 = 0; req1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_result0", result0, 0);
        rst = 0;
        step();

        // simultaneous pairs: port0 first both times
        run_pair(16'd48, 16'd18, 16'd35, 16'd21, t0, t1);
        chk("pair1_order", t0 < t1, 1);
        chk("pair1_res0", result0, 6);
        chk("pair1_res1", result1, 7);
        run_pair(16'd20, 16'd8, 16'd9, 16'd6, t0, t1);
        chk("pair2_order", t0 < t1, 1);
        chk("pair2_res0", result0, 4);
        chk("pair2_res1", result1, 3);

        run_job(0, 16'd143, 16'd78, lat, r);
        chk("j143_lat", lat, 11);
        chk("j143_res", r, 13);
`ifdef GCD_ITER_CNT_EN
        chk("j143_iter", iter_cnt, 6);
`endif
        run_job(1, 16'd0, 16'd9, lat, r);
        chk("byp_lat", lat, 2);
        chk("byp_res", r, 9);
        run_job(1, 16'd0, 16'd0, lat, r);
        chk("byp00_res", r, 0);
        run_job(0, 16'd7, 16'd7, lat, r);
        chk("eq_lat", lat, 5);
        chk("eq_res", r, 7);

        // reset during ITER of a very long job
        a0 = 16'd65535; b0 = 16'd1; req0 = 1;
        for (int k = 0; k < 8; k++) step();
        rst = 1;
        step();
        chk("midrst_out",
            {gnt0, gnt1, done0, done1, busy, ldA, ldB, sel1, sel2, sel_in}, 0);
        chk("midrst_vals", {result0, result1, data_in}, 0);
        rst = 0;
        lat = -1;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            step();
            if (gnt0) lat = k;
        end
        chk("regrant_lat", lat, 2);
        rst = 1; req0 = 0;
        step();
        rst = 0;
        step();

        // randomized traffic
        wt0 = 0; wt1 = 0;
        for (int k = 0; k < 6000; k++) begin
            if ($urandom_range(799) == 0) rst = 1;
            step();
            rst = 0;
            if (req0 && gnt0) begin req0 = 0; wt0 = $urandom_range(3); end
            else if (req0 && $urandom_range(40) == 0) req0 = 0;
            else if (!req0 && wt0 == 0 && $urandom_range(2) == 0) begin
                a0 = rnd_op(); b0 = rnd_op(); req0 = 1;
            end else if (wt0 > 0) wt0--;
            if (req1 && gnt1) begin req1 = 0; wt1 = $urandom_range(3); end
            else if (req1 && $urandom_range(40) == 0) req1 = 0;
            else if (!req1 && wt1 == 0 && $urandom_range(2) == 0) begin
                a1 = rnd_op(); b1 = rnd_op(); req1 = 1;
            end else if (wt1 > 0) wt1--;
        end
        req0 = 0; req1 = 0;
        for (int k = 0; k < 1200 && m_act; k++) step();
        chk("drain", m_act, 0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
